// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type, working-variable struct and the
// standard bitwise helper functions.
package sha256_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StUpdate,
        StWrite
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd7) ^ rightrotate(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd17) ^ rightrotate(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd2) ^ rightrotate(x, 5'd13) ^ rightrotate(x, 5'd22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd6) ^ rightrotate(x, 5'd11) ^ rightrotate(x, 5'd25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the working variables a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       work_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output work_t       work_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = work_i.h + Sigma1(work_i.e) + ch(work_i.e, work_i.f, work_i.g) + k_i + w_i;
        t2 = Sigma0(work_i.a) + maj(work_i.a, work_i.b, work_i.c);
        work_o.a = t1 + t2;
        work_o.b = work_i.a;
        work_o.c = work_i.b;
        work_o.d = work_i.c;
        work_o.e = work_i.d + t1;
        work_o.f = work_i.e;
        work_o.g = work_i.f;
        work_o.h = work_i.g;
    end

endmodule

// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 engine: reads an N-word message from memory, pads it on the fly,
// compresses one round per cycle with a 16-word schedule window and writes back H0..H7.
module sha256_multiblock
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int unsigned NumBlocks = (NUM_OF_WORDS + 18) / 16;
    localparam int unsigned PadLast   = NumBlocks * 16 - 1;
    localparam logic [31:0] BitLen    = 32'(NUM_OF_WORDS * 32);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       h_q [8];
    logic [31:0]       h_d [8];
    work_t             work_q, work_d, round_out;
    logic [31:0]       win_q [16];
    logic [31:0]       win_d [16];
    logic [15:0]       blk_q, blk_d;
    logic [6:0]        cnt_q, cnt_d;

    logic [31:0] rd_g, cap_g, rd_idx, pad_word, sched, w_cur;
    logic [3:0]  cap_slot;

    assign mem_clk = clk;

    // Read index runs one cycle ahead of the capture index because of the memory latency.
    always_comb begin
        rd_g     = {12'd0, blk_q, 4'd0} + {25'd0, cnt_q};
        cap_g    = rd_g - 32'd1;
        cap_slot = cap_g[3:0];
        rd_idx   = (rd_g < NUM_OF_WORDS) ? rd_g : NUM_OF_WORDS - 1;
        if (cap_g < NUM_OF_WORDS) begin
            pad_word = mem_read_data;
        end else if (cap_g == NUM_OF_WORDS) begin
            pad_word = 32'h8000_0000;
        end else if (cap_g == PadLast) begin
            pad_word = BitLen;
        end else begin
            pad_word = 32'd0;
        end
        sched = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
        w_cur = (cnt_q < 7'd16) ? win_q[0] : sched;
    end

    sha256_round u_round (
        .work_i (work_q),
        .w_i    (w_cur),
        .k_i    (K[cnt_q[5:0]]),
        .work_o (round_out)
    );

    always_comb begin
        done           = (state_q == StIdle);
        mem_we         = (state_q == StWrite);
        mem_addr       = '0;
        mem_write_data = '0;
        unique case (state_q)
            StWrite: begin
                mem_addr       = out_addr_q + ADDR_W'(cnt_q[2:0]);
                mem_write_data = h_q[cnt_q[2:0]];
            end
            StLoad, StCompute, StUpdate: mem_addr = msg_addr_q + ADDR_W'(rd_idx);
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        msg_addr_d = msg_addr_q;
        out_addr_d = out_addr_q;
        h_d        = h_q;
        work_d     = work_q;
        win_d      = win_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    msg_addr_d = message_addr;
                    out_addr_d = output_addr;
                    h_d        = IV;
                    work_d     = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
                    blk_d      = '0;
                    cnt_d      = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (cnt_q != 7'd0) begin
                    win_d[cap_slot] = pad_word;
                end
                if (cnt_q == 7'd16) begin
                    cnt_d   = '0;
                    state_d = StCompute;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StCompute: begin
                // Rotating the first 16 words back in leaves W[r-16..r-1] in place at r=16.
                work_d = round_out;
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_cur;
                if (cnt_q == 7'd63) begin
                    cnt_d   = '0;
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StUpdate: begin
                h_d[0] = h_q[0] + work_q.a;
                h_d[1] = h_q[1] + work_q.b;
                h_d[2] = h_q[2] + work_q.c;
                h_d[3] = h_q[3] + work_q.d;
                h_d[4] = h_q[4] + work_q.e;
                h_d[5] = h_q[5] + work_q.f;
                h_d[6] = h_q[6] + work_q.g;
                h_d[7] = h_q[7] + work_q.h;
                blk_d  = blk_q + 16'd1;
                cnt_d  = '0;
                if ({16'd0, blk_q} + 32'd1 < NumBlocks) begin
                    work_d  = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
                    state_d = StLoad;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (cnt_q == 7'd7) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            msg_addr_q <= '0;
            out_addr_q <= '0;
            work_q     <= '0;
            blk_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            msg_addr_q <= msg_addr_d;
            out_addr_q <= out_addr_d;
            work_q     <= work_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            win_q      <= win_d;
        end
    end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Scoreboard bench: five engines (N = 1, 4, 13, 14, 20) share one synchronous-read memory;
// expected digest writes are queued at issue time and checked by a separate write monitor.
module tb_sha256_multiblock;

    localparam int NDUT = 5;

    typedef struct {
        int          dut;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_s  [NDUT];
    logic [15:0] maddr    [NDUT];
    logic [15:0] oaddr    [NDUT];
    logic        done_s   [NDUT];
    logic        mclk     [NDUT];
    logic        we_s     [NDUT];
    logic [15:0] addr_s   [NDUT];
    logic [31:0] wdata_s  [NDUT];
    logic [31:0] rdata_s  [NDUT];
    logic [31:0] mem      [0:65535];

    exp_t        exp_q [$];
    logic [31:0] dig [8];
    int          checks = 0;
    int          errors = 0;
    int          nwr    = 0;
    int          bad_rd = 0;
    int          act    = 0;
    int          act_n  = 1;
    logic [15:0] act_ma = '0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        sha256_multiblock #(
            .NUM_OF_WORDS (gi == 0 ? 1 : gi == 1 ? 4 : gi == 2 ? 13 : gi == 3 ? 14 : 20),
            .ADDR_W       (16)
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start_s[gi]),
            .message_addr   (maddr[gi]),
            .output_addr    (oaddr[gi]),
            .done           (done_s[gi]),
            .mem_clk        (mclk[gi]),
            .mem_we         (we_s[gi]),
            .mem_addr       (addr_s[gi]),
            .mem_write_data (wdata_s[gi]),
            .mem_read_data  (rdata_s[gi])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            rdata_s[i] <= mem[addr_s[i]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference SHA-256 over the padded message read straight from the bench memory.
    task automatic model(input int n, input logic [15:0] ma);
        int          nb;
        logic [31:0] w [64];
        logic [31:0] hh [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        nb = (n + 18) / 16;
        hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < nb; blk++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) begin
                    int gw;
                    gw = blk * 16 + t;
                    if (gw < n) w[t] = mem[16'(ma + 16'(gw))];
                    else if (gw == n) w[t] = 32'h8000_0000;
                    else if (gw == nb * 16 - 1) w[t] = 32'(n * 32);
                    else w[t] = 32'd0;
                end else begin
                    s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                    s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                    w[t] = w[t-16] + s0 + w[t-7] + s1;
                end
            end
            a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
            e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
            for (int t = 0; t < 64; t++) begin
                t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
                     + sha256_pkg::K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
            hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
        end
        dig = hh;
    endtask

    task automatic push_dig(input int i, input logic [15:0] oa);
        exp_t x;
        for (int k = 0; k < 8; k++) begin
            x.dut  = i;
            x.addr = oa + 16'(k);
            x.data = dig[k];
            exp_q.push_back(x);
        end
    endtask

    task automatic push_const(input int i, input logic [15:0] oa, input logic [255:0] v);
        for (int k = 0; k < 8; k++) begin
            dig[k] = v[255-32*k -: 32];
        end
        push_dig(i, oa);
    endtask

    // Starts dut i, waits for done and checks latency, write count and read range.
    task automatic run(input int i, input int n, input logic [15:0] ma, input logic [15:0] oa,
                       input bit hold);
        int nb, edges, wr0, rd0;
        bit pulsed;
        nb     = (n + 18) / 16;
        act    = i;
        act_n  = n;
        act_ma = ma;
        maddr[i] = ma;
        oaddr[i] = oa;
        wr0    = nwr;
        rd0    = bad_rd;
        pulsed = 1'b0;
        start_s[i] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_s[i] = 1'b0;
        edges = 0;
        while (done_s[i] !== 1'b1 && edges < 2000) begin
            @(posedge clk); #1;
            edges++;
            if (hold) begin
                if (edges == 60) start_s[i] = 1'b0;
                if (we_s[i] === 1'b1 && !pulsed) begin
                    start_s[i] = 1'b1;
                    pulsed = 1'b1;
                end else if (pulsed) begin
                    start_s[i] = 1'b0;
                end
            end
        end
        start_s[i] = 1'b0;
        chk($sformatf("latency dut%0d", i), edges, nb * 82 + 8);
        repeat (20) @(posedge clk);
        #1;
        chk($sformatf("idle after run dut%0d", i), done_s[i], 1);
        chk($sformatf("write count dut%0d", i), nwr - wr0, 8);
        chk($sformatf("out-of-range reads dut%0d", i), bad_rd - rd0, 0);
    endtask

    // Write monitor and read-range watcher.
    initial begin
        exp_t x;
        logic [15:0] off;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (we_s[i] === 1'b1) begin
                    nwr++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected write dut%0d: got addr %h data %h, required none",
                                 i, addr_s[i], wdata_s[i]);
                    end else begin
                        x = exp_q.pop_front();
                        chk($sformatf("write dut%0d", i), {4'(i), addr_s[i], wdata_s[i]},
                            {4'(x.dut), x.addr, x.data});
                    end
                end
            end
            if (done_s[act] === 1'b0 && we_s[act] === 1'b0) begin
                off = addr_s[act] - act_ma;
                if (int'(off) >= act_n) bad_rd++;
            end
        end
    end

    initial begin
        logic [31:0] abc56 [14];
        abc56 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                  32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                  32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < NDUT; i++) begin
            start_s[i] = 1'b0;
            maddr[i]   = '0;
            oaddr[i]   = '0;
        end
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("reset done", done_s[0], 1);
        chk("reset mem_we", we_s[0], 0);
        chk("reset mem_addr", addr_s[0], 0);
        chk("reset mem_write_data", wdata_s[0], 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mem_clk follows clk", mclk[0], 1);

        // N=1 "abcd"
        mem[16'h0100] = 32'h61626364;
        push_const(0, 16'h0200, {32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
                                 32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589});
        run(0, 1, 16'h0100, 16'h0200, 1'b0);

        // N=14 known two-block vector
        for (int k = 0; k < 14; k++) mem[16'h0300 + 16'(k)] = abc56[k];
        push_const(3, 16'h0400, {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                 32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1});
        run(3, 14, 16'h0300, 16'h0400, 1'b0);

        // N=13 single block at the boundary
        for (int k = 0; k < 13; k++) mem[16'h0500 + 16'(k)] = $urandom;
        model(13, 16'h0500);
        push_dig(2, 16'h0600);
        run(2, 13, 16'h0500, 16'h0600, 1'b0);

        // N=20 two blocks
        for (int k = 0; k < 20; k++) mem[16'h0700 + 16'(k)] = $urandom;
        model(20, 16'h0700);
        push_dig(4, 16'h0800);
        run(4, 20, 16'h0700, 16'h0800, 1'b0);

        // Reset during COMPUTE of block 0 aborts with no writes
        act = 4; act_n = 20; act_ma = 16'h0700;
        maddr[4] = 16'h0700;
        oaddr[4] = 16'h0900;
        start_s[4] = 1'b1;
        @(posedge clk); #1;
        start_s[4] = 1'b0;
        repeat (27) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort done", done_s[4], 1);
        chk("abort mem_we", we_s[4], 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        model(20, 16'h0700);
        push_dig(4, 16'h0900);
        run(4, 20, 16'h0700, 16'h0900, 1'b0);

        // start held high plus a second pulse during WRITE
        for (int k = 0; k < 20; k++) mem[16'h0a00 + 16'(k)] = $urandom;
        model(20, 16'h0a00);
        push_dig(4, 16'h0b00);
        run(4, 20, 16'h0a00, 16'h0b00, 1'b1);

        // Address wrap for reads and writes
        mem[16'hfffe] = 32'hdeadbeef;
        mem[16'hffff] = 32'h01234567;
        mem[16'h0000] = 32'h89abcdef;
        mem[16'h0001] = 32'hcafef00d;
        model(4, 16'hfffe);
        push_dig(1, 16'hfffc);
        run(1, 4, 16'hfffe, 16'hfffc, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
